// File: rtl/bitserial_pkg.sv
// Shared opcodes, control encodings, FSM states and decode helpers for the
// bit-serial PE array sequencer.
package bitserial_pkg;

  localparam logic [5:0] OP_ADD    = 6'd0;
  localparam logic [5:0] OP_SUB    = 6'd1;
  localparam logic [5:0] OP_MOVE_E = 6'd5;
  localparam logic [5:0] OP_MOVE_W = 6'd6;
  localparam logic [5:0] OP_MOVE_S = 6'd7;
  localparam logic [5:0] OP_MOVE_N = 6'd8;
  localparam logic [5:0] OP_ADDR   = 6'd9;
  localparam logic [5:0] OP_SUBR   = 6'd10;

  localparam logic [3:0] ALU_MOVE = 4'hF;

  localparam logic [1:0] MODE_IDLE   = 2'd0;
  localparam logic [1:0] MODE_STREAM = 2'd1;
  localparam logic [1:0] MODE_LATCH  = 2'd2;

  // One-hot {N,S,W,E}; bit positions line up with LATCH_MASK.
  localparam logic [3:0] DIR_NONE = 4'b0000;
  localparam logic [3:0] DIR_E    = 4'b0001;
  localparam logic [3:0] DIR_W    = 4'b0010;
  localparam logic [3:0] DIR_S    = 4'b0100;
  localparam logic [3:0] DIR_N    = 4'b1000;

  typedef enum logic [2:0] {IDLE, RD, WB, LATCH, DONE} state_t;

  // Upper instruction fields; bits [10:0] carry nothing the sequencer uses.
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } instr_hdr_t;

  function automatic logic is_arith_op(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDR) || (op == OP_SUBR);
  endfunction

  function automatic logic is_move_op(input logic [5:0] op);
    return (op == OP_MOVE_E) || (op == OP_MOVE_W) || (op == OP_MOVE_S) || (op == OP_MOVE_N);
  endfunction

  function automatic logic is_msb_op(input logic [5:0] op);
    return (op == OP_ADDR) || (op == OP_SUBR);
  endfunction

  function automatic logic [3:0] move_dir_of(input logic [5:0] op);
    logic [3:0] d;
    case (op)
      OP_MOVE_E: d = DIR_E;
      OP_MOVE_W: d = DIR_W;
      OP_MOVE_S: d = DIR_S;
      OP_MOVE_N: d = DIR_N;
      default:   d = DIR_NONE;
    endcase
    return d;
  endfunction

  function automatic int reg_base(input logic [4:0] idx, input int wlen);
    return int'(idx) * wlen;
  endfunction

endpackage

// File: rtl/bitserial_addr_gen.sv
// Register-base pointer generator: walks bit offsets up or down with stride 1 (ALU)
// or 2 (moves); pointers are combinational from registered state, advanced by step.
module bitserial_addr_gen
  import bitserial_pkg::*;
#(
  parameter int WORD_LEN = 32,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [4:0]        rd_idx,
  input  logic [4:0]        rs1_idx,
  input  logic [4:0]        rs2_idx,
  input  logic              msb_first,
  input  logic              pair_mode,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [ADDR_W-1:0] wb_addr_a,
  output logic [ADDR_W-1:0] wb_addr_b,
  output logic              last
);

  localparam int OFF_W = 7;
  localparam logic [OFF_W-1:0] ONE       = OFF_W'(1);
  localparam logic [OFF_W-1:0] TWO       = OFF_W'(2);
  localparam logic [OFF_W-1:0] TOP_BIT   = OFF_W'(WORD_LEN - 1);
  localparam logic [OFF_W-1:0] LAST_PAIR = OFF_W'(WORD_LEN / 2 - 1);

  logic [ADDR_W-1:0] rd_base, rs1_base, rs2_base;
  logic [OFF_W-1:0]  off, cnt;
  logic              down, pair;
  logic [ADDR_W-1:0] off_ext;

  assign off_ext = ADDR_W'(off);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_base  <= '0;
      rs1_base <= '0;
      rs2_base <= '0;
      off      <= '0;
      cnt      <= '0;
      down     <= 1'b0;
      pair     <= 1'b0;
    end else if (load) begin
      rd_base  <= ADDR_W'(reg_base(rd_idx, WORD_LEN));
      rs1_base <= ADDR_W'(reg_base(rs1_idx, WORD_LEN));
      rs2_base <= ADDR_W'(reg_base(rs2_idx, WORD_LEN));
      off      <= msb_first ? TOP_BIT : '0;
      cnt      <= '0;
      down     <= msb_first;
      pair     <= pair_mode;
    end else if (step) begin
      off <= down ? (off - ONE) : (off + (pair ? TWO : ONE));
      cnt <= cnt + ONE;
    end
  end

  // Moves read/write a bit pair from one register; ALU ops read rs1/rs2 side by side.
  assign rd_addr_a = rs1_base + off_ext;
  assign rd_addr_b = pair ? (rs1_base + off_ext + ADDR_W'(1)) : (rs2_base + off_ext);
  assign wb_addr_a = rd_base + off_ext;
  assign wb_addr_b = rd_base + off_ext + ADDR_W'(1);
  assign last      = (cnt == (pair ? LAST_PAIR : TOP_BIT));

endmodule

// File: rtl/bitserial_pe_sequencer.sv
// Bit-serial PE array sequencer: one instruction per handshake, 2 cycles per bit (ALU)
// or per bit pair (moves) plus optional latch and a done pulse; ready only when idle.
module bitserial_pe_sequencer
  import bitserial_pkg::*;
#(
  parameter int         WORD_LEN   = 32,
  parameter int         NUM_REGS   = 32,
  parameter int         ADDR_W     = 10,
  parameter logic [3:0] LATCH_MASK = 4'b1011
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [3:0]        alu_op,
  output logic              wea,
  output logic              web,
  output logic [ADDR_W-1:0] addra,
  output logic [ADDR_W-1:0] addrb,
  output logic [3:0]        move_dir,
  output logic [1:0]        move_mode,
  output logic [4:0]        num_shift,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int AW1 = ADDR_W + 1;

  state_t     state;
  instr_hdr_t instr_in, instr_q;
  logic       accept;
  logic       unused_instr_low;

  assign instr_in         = instr_hdr_t'(instr[31:11]);
  assign unused_instr_low = ^instr[10:0];
  assign instr_ready      = (state == IDLE) && reset;
  assign accept           = instr_valid && instr_ready;

  // Base is formed one bit wider than the BRAM address so overflow is visible.
  function automatic logic reg_ok(input logic [4:0] idx);
    logic [AW1-1:0] base;
    base = AW1'(reg_base(idx, WORD_LEN));
    return (int'(idx) < NUM_REGS) && (base <= AW1'((2 ** ADDR_W) - 1));
  endfunction

  logic       is_move, legal, latch_en;
  logic [3:0] dir;

  always_comb begin
    is_move  = is_move_op(instr_q.opcode);
    dir      = move_dir_of(instr_q.opcode);
    latch_en = |(dir & LATCH_MASK);
    legal    = 1'b0;
    if (is_arith_op(instr_q.opcode))
      legal = reg_ok(instr_q.rd) && reg_ok(instr_q.rs1) && reg_ok(instr_q.rs2);
    else if (is_move)
      legal = reg_ok(instr_q.rd) && reg_ok(instr_q.rs1);
  end

  logic [ADDR_W-1:0] gen_rd_a, gen_rd_b, gen_wb_a, gen_wb_b;
  logic              gen_last;

  bitserial_addr_gen #(
    .WORD_LEN (WORD_LEN),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .step      (state == WB),
    .rd_idx    (instr_in.rd),
    .rs1_idx   (instr_in.rs1),
    .rs2_idx   (instr_in.rs2),
    .msb_first (is_msb_op(instr_in.opcode)),
    .pair_mode (is_move_op(instr_in.opcode)),
    .rd_addr_a (gen_rd_a),
    .rd_addr_b (gen_rd_b),
    .wb_addr_a (gen_wb_a),
    .wb_addr_b (gen_wb_b),
    .last      (gen_last)
  );

  // State names the phase the outputs will show after the next edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      instr_q   <= '0;
      alu_op    <= '0;
      wea       <= 1'b0;
      web       <= 1'b0;
      addra     <= '0;
      addrb     <= '0;
      move_dir  <= DIR_NONE;
      move_mode <= MODE_IDLE;
      num_shift <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            instr_q <= instr_in;
            state   <= RD;
          end
        end
        RD: begin
          busy <= 1'b1;
          if (!legal) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= DONE;
          end else begin
            addra     <= gen_rd_a;
            addrb     <= gen_rd_b;
            wea       <= 1'b0;
            web       <= 1'b0;
            alu_op    <= is_move ? ALU_MOVE : instr_q.opcode[3:0];
            move_dir  <= dir;
            move_mode <= is_move ? MODE_STREAM : MODE_IDLE;
            num_shift <= is_move ? instr_q.rs2 : '0;
            state     <= WB;
          end
        end
        WB: begin
          addra <= gen_wb_a;
          wea   <= 1'b1;
          if (is_move) begin
            addrb <= gen_wb_b;
            web   <= 1'b1;
          end
          if (!gen_last)
            state <= RD;
          else if (is_move && latch_en)
            state <= LATCH;
          else
            state <= DONE;
        end
        LATCH: begin
          wea       <= 1'b0;
          web       <= 1'b0;
          move_mode <= MODE_LATCH;
          state     <= DONE;
        end
        DONE: begin
          if (done) begin
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            alu_op    <= '0;
            num_shift <= '0;
            state     <= IDLE;
          end else begin
            done      <= 1'b1;
            wea       <= 1'b0;
            web       <= 1'b0;
            move_dir  <= DIR_NONE;
            move_mode <= MODE_IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitserial_pe_sequencer.sv
// Scoreboard bench: directed instructions push expected per-edge values and done pulses;
// a negedge monitor pops and compares them against the sequencer outputs.
module tb_bitserial_pe_sequencer;
  import bitserial_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          instr_valid = 1'b0;
  logic [31:0]   instr = '0;
  logic          instr_ready;
  logic [3:0]    alu_op;
  logic          wea, web;
  logic [AW-1:0] addra, addrb;
  logic [3:0]    move_dir;
  logic [1:0]    move_mode;
  logic [4:0]    num_shift;
  logic          busy, done, err;

  bitserial_pe_sequencer #(
    .WORD_LEN(32), .NUM_REGS(32), .ADDR_W(AW), .LATCH_MASK(4'b1011)
  ) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_op(alu_op), .wea(wea), .web(web), .addra(addra), .addrb(addrb),
    .move_dir(move_dir), .move_mode(move_mode), .num_shift(num_shift),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_chk = 0;
  int n_pass = 0;

  typedef enum {S_ADDRA, S_ADDRB, S_WEA, S_WEB, S_MODE, S_DIR, S_SHIFT, S_BUSY, S_READY, S_ALU} sel_e;
  typedef struct { int cyc; sel_e sel; logic [31:0] exp; string name; } chk_t;
  typedef struct { int cyc; logic err; } done_t;

  chk_t  chk_q[$];
  done_t done_q[$];

  function automatic logic [31:0] sig_val(input sel_e s);
    case (s)
      S_ADDRA: return 32'(addra);
      S_ADDRB: return 32'(addrb);
      S_WEA:   return 32'(wea);
      S_WEB:   return 32'(web);
      S_MODE:  return 32'(move_mode);
      S_DIR:   return 32'(move_dir);
      S_SHIFT: return 32'(num_shift);
      S_BUSY:  return 32'(busy);
      S_READY: return 32'(instr_ready);
      default: return 32'(alu_op);
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic expect_at(input int cyc, input sel_e sel, input logic [31:0] v, input string nm);
    chk_t c;
    int   i;
    c.cyc = cyc; c.sel = sel; c.exp = v; c.name = nm;
    i = chk_q.size();
    while (i > 0 && chk_q[i-1].cyc > cyc) i--;
    chk_q.insert(i, c);
  endtask

  task automatic expect_done(input int cyc, input logic e);
    done_t d;
    d.cyc = cyc; d.err = e;
    done_q.push_back(d);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'd0};
  endfunction

  // Offers ins until accepted; acc is the number of the accepting posedge.
  task automatic issue(input logic [31:0] ins, input bit drop_valid, output int acc);
    int n;
    n = 0;
    instr = ins;
    instr_valid = 1'b1;
    while (instr_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_chk++;
      $display("FAIL issue_timeout: instr_ready stayed %b, expected 1", instr_ready);
      acc = -1000;
    end else begin
      acc = edge_cnt + 1;
      @(posedge clk);
      #1;
    end
    if (drop_valid) instr_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    chk_t  c;
    done_t d;
    while (chk_q.size() != 0 && chk_q[0].cyc <= edge_cnt) begin
      c = chk_q.pop_front();
      if (c.cyc < edge_cnt) check({c.name, "_missed"}, 32'(edge_cnt), 32'(c.cyc));
      else check(c.name, sig_val(c.sel), c.exp);
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        check("unexpected_done_cycle", 32'(edge_cnt), 32'hFFFF_FFFF);
      end else begin
        d = done_q.pop_front();
        check("done_cycle", 32'(edge_cnt), 32'(d.cyc));
        check("done_err", 32'(err), 32'(d.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    int a, b;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_ready", 32'(instr_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_addra", 32'(addra), 0);
    check("rst_wea", 32'(wea), 0);
    check("rst_mode", 32'(move_mode), 0);
    @(negedge clk);

    // ADD rd=3 rs1=1 rs2=2, LSB first
    issue(mk(OP_ADD, 3, 1, 2), 1, a);
    expect_at(a,      S_BUSY,  0,   "add_e0_busy");
    expect_at(a,      S_READY, 0,   "add_e0_ready");
    expect_at(a + 1,  S_ADDRA, 32,  "add_e1_addra");
    expect_at(a + 1,  S_ADDRB, 64,  "add_e1_addrb");
    expect_at(a + 1,  S_WEA,   0,   "add_e1_wea");
    expect_at(a + 1,  S_BUSY,  1,   "add_e1_busy");
    expect_at(a + 1,  S_ALU,   0,   "add_e1_alu");
    expect_at(a + 2,  S_ADDRA, 96,  "add_e2_addra");
    expect_at(a + 2,  S_WEA,   1,   "add_e2_wea");
    expect_at(a + 2,  S_WEB,   0,   "add_e2_web");
    expect_at(a + 3,  S_ADDRA, 33,  "add_e3_addra");
    expect_at(a + 3,  S_ADDRB, 65,  "add_e3_addrb");
    expect_at(a + 64, S_ADDRA, 127, "add_e64_addra");
    expect_at(a + 64, S_WEA,   1,   "add_e64_wea");
    expect_at(a + 65, S_WEA,   0,   "add_e65_wea");
    expect_at(a + 65, S_BUSY,  1,   "add_e65_busy");
    expect_at(a + 65, S_READY, 0,   "add_e65_ready");
    expect_at(a + 66, S_BUSY,  0,   "add_e66_busy");
    expect_at(a + 66, S_READY, 1,   "add_e66_ready");
    expect_done(a + 65, 1'b0);

    // SUBR rd=0 rs1=4 rs2=5, MSB first
    issue(mk(OP_SUBR, 0, 4, 5), 1, a);
    expect_at(a + 1,  S_ADDRA, 159, "subr_e1_addra");
    expect_at(a + 1,  S_ADDRB, 191, "subr_e1_addrb");
    expect_at(a + 1,  S_ALU,   10,  "subr_e1_alu");
    expect_at(a + 2,  S_ADDRA, 31,  "subr_e2_addra");
    expect_at(a + 2,  S_WEA,   1,   "subr_e2_wea");
    expect_at(a + 64, S_ADDRA, 0,   "subr_e64_addra");
    expect_done(a + 65, 1'b0);

    // ADDR rd=7 rs1=8 rs2=9
    issue(mk(OP_ADDR, 7, 8, 9), 1, a);
    expect_at(a + 1,  S_ADDRA, 287, "addr_e1_addra");
    expect_at(a + 1,  S_ADDRB, 319, "addr_e1_addrb");
    expect_at(a + 1,  S_ALU,   9,   "addr_e1_alu");
    expect_at(a + 2,  S_ADDRA, 255, "addr_e2_addra");
    expect_at(a + 63, S_ADDRA, 256, "addr_e63_addra");
    expect_at(a + 63, S_ADDRB, 288, "addr_e63_addrb");
    expect_at(a + 64, S_ADDRA, 224, "addr_e64_addra");
    expect_done(a + 65, 1'b0);

    // MOVE_E rd=2 src=2 shift=3, east latches
    issue(mk(OP_MOVE_E, 2, 2, 3), 1, a);
    expect_at(a + 1,  S_ADDRA, 64, "mve_e1_addra");
    expect_at(a + 1,  S_ADDRB, 65, "mve_e1_addrb");
    expect_at(a + 1,  S_SHIFT, 3,  "mve_e1_shift");
    expect_at(a + 1,  S_DIR,   1,  "mve_e1_dir");
    expect_at(a + 1,  S_MODE,  1,  "mve_e1_mode");
    expect_at(a + 1,  S_ALU,   15, "mve_e1_alu");
    expect_at(a + 1,  S_WEA,   0,  "mve_e1_wea");
    expect_at(a + 2,  S_ADDRA, 64, "mve_e2_addra");
    expect_at(a + 2,  S_WEA,   1,  "mve_e2_wea");
    expect_at(a + 2,  S_WEB,   1,  "mve_e2_web");
    expect_at(a + 3,  S_ADDRA, 66, "mve_e3_addra");
    expect_at(a + 3,  S_ADDRB, 67, "mve_e3_addrb");
    expect_at(a + 3,  S_WEB,   0,  "mve_e3_web");
    expect_at(a + 32, S_ADDRA, 94, "mve_e32_addra");
    expect_at(a + 32, S_ADDRB, 95, "mve_e32_addrb");
    expect_at(a + 32, S_WEB,   1,  "mve_e32_web");
    expect_at(a + 33, S_MODE,  2,  "mve_e33_mode");
    expect_at(a + 33, S_WEA,   0,  "mve_e33_wea");
    expect_at(a + 33, S_WEB,   0,  "mve_e33_web");
    expect_at(a + 33, S_DIR,   1,  "mve_e33_dir");
    expect_at(a + 34, S_MODE,  0,  "mve_e34_mode");
    expect_at(a + 34, S_DIR,   0,  "mve_e34_dir");
    expect_at(a + 35, S_BUSY,  0,  "mve_e35_busy");
    expect_at(a + 35, S_SHIFT, 0,  "mve_e35_shift");
    expect_done(a + 34, 1'b0);

    // MOVE_S rd=1 src=0, south does not latch
    issue(mk(OP_MOVE_S, 1, 0, 1), 1, a);
    expect_at(a + 1,  S_ADDRA, 0,  "mvs_e1_addra");
    expect_at(a + 1,  S_ADDRB, 1,  "mvs_e1_addrb");
    expect_at(a + 1,  S_DIR,   4,  "mvs_e1_dir");
    expect_at(a + 2,  S_ADDRA, 32, "mvs_e2_addra");
    expect_at(a + 2,  S_ADDRB, 33, "mvs_e2_addrb");
    expect_at(a + 32, S_ADDRA, 62, "mvs_e32_addra");
    expect_at(a + 32, S_ADDRB, 63, "mvs_e32_addrb");
    expect_at(a + 32, S_WEB,   1,  "mvs_e32_web");
    for (int k = 1; k <= 32; k++) expect_at(a + k, S_MODE, 1, "mvs_mode_stream");
    expect_at(a + 33, S_MODE,  0,  "mvs_e33_mode");
    expect_at(a + 33, S_WEB,   0,  "mvs_e33_web");
    expect_at(a + 33, S_DIR,   0,  "mvs_e33_dir");
    expect_done(a + 33, 1'b0);

    // MOVE_W rd=5 src=6, west latches
    issue(mk(OP_MOVE_W, 5, 6, 0), 1, a);
    expect_at(a + 1,  S_ADDRA, 192, "mvw_e1_addra");
    expect_at(a + 1,  S_ADDRB, 193, "mvw_e1_addrb");
    expect_at(a + 1,  S_DIR,   2,   "mvw_e1_dir");
    expect_at(a + 32, S_ADDRA, 190, "mvw_e32_addra");
    expect_at(a + 32, S_ADDRB, 191, "mvw_e32_addrb");
    expect_at(a + 33, S_MODE,  2,   "mvw_e33_mode");
    expect_done(a + 34, 1'b0);

    // Illegal opcode 3, then ADD offered with valid held high
    issue(mk(6'd3, 3, 1, 2), 0, a);
    instr = mk(OP_ADD, 3, 1, 2);
    expect_at(a + 1, S_WEA,   0,   "ill_e1_wea");
    expect_at(a + 1, S_WEB,   0,   "ill_e1_web");
    expect_at(a + 1, S_ADDRA, 190, "ill_e1_addra");
    expect_at(a + 1, S_ADDRB, 191, "ill_e1_addrb");
    expect_at(a + 1, S_BUSY,  1,   "ill_e1_busy");
    expect_done(a + 1, 1'b1);
    issue(mk(OP_ADD, 3, 1, 2), 1, b);
    check("b2b_accept_edge", 32'(b), 32'(a + 3));
    instr = 32'hFFFF_FFFF;
    expect_at(b + 1,  S_ADDRA, 32,  "b2b_e1_addra");
    expect_at(b + 1,  S_ADDRB, 64,  "b2b_e1_addrb");
    expect_at(b + 2,  S_ADDRA, 96,  "b2b_e2_addra");
    expect_at(b + 2,  S_WEA,   1,   "b2b_e2_wea");
    expect_at(b + 64, S_ADDRA, 127, "b2b_e64_addra");
    expect_done(b + 65, 1'b0);

    // Reset at edge 20 of an ADD drops it with no done pulse
    issue(mk(OP_ADD, 3, 1, 2), 1, a);
    expect_at(a + 18, S_ADDRA, 104, "rst_add_e18_addra");
    expect_at(a + 18, S_WEA,   1,   "rst_add_e18_wea");
    expect_at(a + 19, S_ADDRA, 41,  "rst_add_e19_addra");
    expect_at(a + 19, S_ADDRB, 73,  "rst_add_e19_addrb");
    while (edge_cnt < a + 19) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_addra", 32'(addra), 0);
    check("midrst_addrb", 32'(addrb), 0);
    check("midrst_wea", 32'(wea), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_alu", 32'(alu_op), 0);
    check("midrst_ready_low", 32'(instr_ready), 0);
    reset = 1'b1;
    #1;
    check("midrst_ready", 32'(instr_ready), 1);
    repeat (80) @(negedge clk);

    check("chk_q_drained", 32'(chk_q.size()), 0);
    check("done_q_drained", 32'(done_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
